// File: rtl/result_trace_buffer.sv
// result_trace_buffer
// Captures the processor PC and result every enabled cycle and timestamps each
// pair with a free-running 16-bit cycle counter. Entries are queued in a FIFO
// and drained over a valid/ready port. Captures are dropped when the FIFO is
// full and no pop frees a slot in the same cycle; the drop sets a sticky flag.
//
// Optional feature: define TRACE_DEDUP_EN to suppress a capture when the PC
// matches the last capture attempt. This keeps stalled or self-looping PCs
// from filling the FIFO.
module result_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [31:0]      addr,
    input  logic [31:0]      Result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_result,
    output logic [15:0]      out_cycle,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    logic [31:0] addr_mem_q   [DEPTH];
    logic [31:0] result_mem_q [DEPTH];
    logic [15:0] cyc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      cyc_q, cyc_d;
    logic             overflow_q, overflow_d;

    logic empty;
    logic full;
    logic attempt;
    logic push;
    logic pop;

`ifdef TRACE_DEDUP_EN
    logic [31:0] last_addr_q, last_addr_d;
    logic        last_vld_q, last_vld_d;
    logic        suppress;

    assign suppress = last_vld_q && (addr == last_addr_q);
    assign attempt  = En && !suppress;

    // Remember the PC of every capture attempt that got past the dedup filter.
    always_comb begin
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        if (attempt) begin
            last_addr_d = addr;
            last_vld_d  = 1'b1;
        end
    end

    // Dedup history register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign attempt = En;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCnt);

    // A pop only depends on state and out_ready, so out_valid never loops back.
    assign pop  = !empty && out_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push = attempt && (!full || pop);

    // Next-state for pointers, occupancy, timestamp counter and loss flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cyc_d      = cyc_q + 16'd1;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (attempt && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; the entry carries the counter value before this edge.
    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            addr_mem_q[wr_ptr_q]   <= addr;
            result_mem_q[wr_ptr_q] <= Result;
            cyc_mem_q[wr_ptr_q]    <= cyc_q;
        end
    end

    // Head entry presentation, zeroed while the FIFO is empty.
    always_comb begin
        out_valid  = !empty;
        out_addr   = '0;
        out_result = '0;
        out_cycle  = '0;
        if (!empty) begin
            out_addr   = addr_mem_q[rd_ptr_q];
            out_result = result_mem_q[rd_ptr_q];
            out_cycle  = cyc_mem_q[rd_ptr_q];
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_result_trace_buffer.sv
// Self-checking bench for result_trace_buffer: directed scenarios with literal
// expectations plus a randomized phase, all compared against a queue model.
module tb_result_trace_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             Clock;
    logic             Reset;
    logic             En;
    logic [31:0]      addr;
    logic [31:0]      Result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_addr;
    logic [31:0]      out_result;
    logic [15:0]      out_cycle;
    logic [PTR_W:0]   count;
    logic             overflow;

    result_trace_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .En         (En),
        .addr       (addr),
        .Result     (Result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_result (out_result),
        .out_cycle  (out_cycle),
        .count      (count),
        .overflow   (overflow)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of entries plus a few scalars.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] r;
        logic [15:0] c;
    } ent_t;

    ent_t        mq[$];
    int          m_cyc = 0;
    bit          m_ovf = 0;
    bit          m_last_vld = 0;
    logic [31:0] m_last_addr = '0;
    bit          model_live = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            mq.delete();
            m_cyc      = 0;
            m_ovf      = 0;
            m_last_vld = 0;
            model_live = 1;
        end else begin
            bit do_pop;
            bit try_push;
            int size_before;
            size_before = mq.size();
            do_pop      = (size_before != 0) && out_ready;
            try_push    = En;
`ifdef TRACE_DEDUP_EN
            if (m_last_vld && addr == m_last_addr) try_push = 0;
            if (try_push) begin
                m_last_vld  = 1;
                m_last_addr = addr;
            end
`endif
            if (do_pop) void'(mq.pop_front());
            if (try_push) begin
                if (size_before == DEPTH && !do_pop) m_ovf = 1;
                else mq.push_back('{a: addr, r: Result, c: 16'(m_cyc)});
            end
            m_cyc = (m_cyc + 1) % 65536;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (model_live) begin
            check("m_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("m_count", 32'(count), 32'(mq.size()));
            check("m_overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) begin
                check("m_addr", out_addr, mq[0].a);
                check("m_result", out_result, mq[0].r);
                check("m_cycle", 32'(out_cycle), 32'(mq[0].c));
            end else begin
                check("m_addr0", out_addr, 32'h0);
                check("m_result0", out_result, 32'h0);
                check("m_cycle0", 32'(out_cycle), 32'h0);
            end
        end
    end

    // Drive one cycle of inputs just after a falling edge, return at the next one.
    task automatic step(input logic rst, input logic en, input logic [31:0] a,
                        input logic [31:0] r, input logic rdy);
        Reset     = rst;
        En        = en;
        addr      = a;
        Result    = r;
        out_ready = rdy;
        @(negedge Clock);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 32'hDEAD_0000, 32'h1, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD_0004, 32'h2, 1'b0);
    endtask

    int expected_dedup;

    initial begin
        Reset = 1'b1; En = 1'b1; addr = '0; Result = '0; out_ready = 1'b0;
        @(negedge Clock);

        // Reset held with En=1: everything reads zero.
        do_reset();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_addr", out_addr, 32'h0);

        // Single entry, first capture after reset carries timestamp 0.
        step(1'b0, 1'b1, 32'h4, 32'h5, 1'b0);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_addr", out_addr, 32'h4);
        check("single_result", out_result, 32'h5);
        check("single_count", 32'(count), 32'h1);
        check("single_cycle", 32'(out_cycle), 32'h0);

        // Fill past capacity with no consumer.
        do_reset();
        for (int i = 0; i <= 16; i++) step(1'b0, 1'b1, 32'(i * 4), 32'(i + 100), 1'b0);
        check("fill_count", 32'(count), 32'd16);
        check("fill_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("drain_addr", out_addr, 32'(i * 4));
            check("drain_cycle", 32'(out_cycle), 32'(i));
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        check("drain_empty", 32'(count), 32'h0);
        check("drain_overflow_sticky", 32'(overflow), 32'h1);

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i * 4), 32'(i), 1'b0);
        step(1'b0, 1'b1, 32'h100, 32'h77, 1'b1);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_overflow", 32'(overflow), 32'h0);
        check("fullpp_head", out_addr, 32'h4);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("fullpp_last", out_addr, 32'h100);
        check("fullpp_last_cnt", 32'(count), 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Streaming through the pointer wrap with a permanent consumer.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'(i), 1'b1);
            check("wrap_count", 32'(count), 32'h1);
            check("wrap_addr", out_addr, 32'h200 + 32'(i * 4));
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("wrap_done", 32'(count), 32'h0);

        // Stalled PC followed by a new PC.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h8, 32'(i), 1'b0);
        step(1'b0, 1'b1, 32'hC, 32'h9, 1'b0);
`ifdef TRACE_DEDUP_EN
        expected_dedup = 2;
`else
        expected_dedup = 6;
`endif
        check("stall_count", 32'(count), 32'(expected_dedup));

        // Randomized traffic with varying consumer pressure and sporadic resets.
        for (int blk = 0; blk < 30; blk++) begin
            int rdy_pct;
            rdy_pct = int'($urandom_range(0, 100));
            for (int i = 0; i < 100; i++) begin
                logic rst_r;
                rst_r = ($urandom_range(0, 299) == 0);
                step(rst_r, ($urandom_range(0, 9) < 7), 32'($urandom_range(0, 5)) * 32'd4,
                     $urandom, (int'($urandom_range(0, 99)) < rdy_pct));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
